// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback block.
//   REG_ADDR_W / REG_ZERO : register index width and the hard-wired zero register
//   reg_addr_t            : register index type
//   wb_tag_t              : control part of a queued memory result {valid, rd};
//                           the full entry (tag + N-bit data) is declared in
//                           wb_fifo because its data width follows parameter N
//   age_width()           : width of the head-age counter for a given STARVE
package rf_wb_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } wb_tag_t;

  function automatic int age_width(input int starve);
    return $clog2(starve + 1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Kill-able circular FIFO of pending memory results.
//   push/push_rd/push_data : enqueue one entry at the tail
//   pop                    : drop the head entry (caller guarantees non-empty)
//   kill_en/kill_rd        : invalidate every entry (including the one being
//                            pushed this cycle) whose rd equals kill_rd
//   head_valid/rd/data     : head entry (head_valid is 0 when empty or killed)
//   count                  : occupancy, killed entries included
//   lk_addr/lk_hit/lk_data : two combinational lookups, youngest valid match wins
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  reg_addr_t                    push_rd,
  input  logic [N-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         kill_en,
  input  reg_addr_t                    kill_rd,
  output logic                         head_valid,
  output reg_addr_t                    head_rd,
  output logic [N-1:0]                 head_data,
  output logic [$clog2(DEPTH):0]       count,
  input  reg_addr_t                    lk_addr [2],
  output logic                         lk_hit  [2],
  output logic [N-1:0]                 lk_data [2]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    wb_tag_t        tag;
    logic [N-1:0]   data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem_q[i].tag.rd == kill_rd) mem_q[i].tag.valid <= 1'b0;
      end
      // A same-cycle push is older than the ALU write that kills it.
      if (push) begin
        mem_q[wr_ptr].tag.valid <= !(kill_en && push_rd == kill_rd);
        mem_q[wr_ptr].tag.rd    <= push_rd;
        mem_q[wr_ptr].data      <= push_data;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0) && mem_q[rd_ptr].tag.valid;
  assign head_rd    = mem_q[rd_ptr].tag.rd;
  assign head_data  = mem_q[rd_ptr].data;

  // Walk oldest to youngest so the youngest occupied match is left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      lk_hit[p]  = 1'b0;
      lk_data[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PW'(k);
        if ((CW'(k) < count_q) && mem_q[idx].tag.valid &&
            (mem_q[idx].tag.rd == lk_addr[p]) && (lk_addr[p] != REG_ZERO)) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = mem_q[idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port driver: merges the ALU result stream (fixed
// priority) with queued memory results into the single write port.
//   alu_valid/alu_rd/alu_data : ALU result, always wins the write slot
//   alu_stall                 : head memory result has waited STARVE cycles
//   mem_valid/mem_ready/...   : memory result handshake into the FIFO
//   rf_we/rf_waddr/rf_wdata   : registered register-file write port
//   byp_addrK/byp_hitK/...    : combinational lookup of uncommitted values
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int N      = 32,
  parameter int DEPTH  = 2,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  reg_addr_t         alu_rd,
  input  logic [N-1:0]      alu_data,
  output logic              alu_stall,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  reg_addr_t         mem_rd,
  input  logic [N-1:0]      mem_data,
  output logic              rf_we,
  output reg_addr_t         rf_waddr,
  output logic [N-1:0]      rf_wdata,
  input  reg_addr_t         byp_addr1,
  input  reg_addr_t         byp_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [N-1:0]      byp_data1,
  output logic [N-1:0]      byp_data2
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AGE_W = age_width(STARVE);

  logic             alu_eff;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [CW-1:0]    count;
  logic             head_valid;
  reg_addr_t        head_rd;
  logic [N-1:0]     head_data;
  logic [AGE_W-1:0] age_p1;
  logic             we_p1;
  reg_addr_t        waddr_p1;
  logic [N-1:0]     wdata_p1;
  reg_addr_t        lk_addr  [2];
  logic             lk_hit   [2];
  logic [N-1:0]     lk_data  [2];
  logic             byp_hit  [2];
  logic [N-1:0]     byp_data [2];

  assign alu_eff    = alu_valid && (alu_rd != REG_ZERO);
  assign mem_ready  = (count < CW'(DEPTH));
  assign fifo_empty = (count == '0);
  // rd=0 results are acknowledged but never queued.
  assign push       = mem_valid && mem_ready && (mem_rd != REG_ZERO);
  assign pop        = !alu_eff && !fifo_empty;

  wb_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (mem_rd),
    .push_data  (mem_data),
    .pop        (pop),
    .kill_en    (alu_eff),
    .kill_rd    (alu_rd),
    .head_valid (head_valid),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (count),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  // Head age: restarts whenever a new entry becomes head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_p1 <= '0;
    end else if (fifo_empty || pop) begin
      age_p1 <= '0;
    end else if (age_p1 < AGE_W'(STARVE)) begin
      age_p1 <= age_p1 + 1'b1;
    end
  end

  assign alu_stall = head_valid && (age_p1 >= AGE_W'(STARVE));

  // ---- stage p1: write-port register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      waddr_p1 <= REG_ZERO;
      wdata_p1 <= '0;
    end else if (alu_eff) begin
      we_p1    <= 1'b1;
      waddr_p1 <= alu_rd;
      wdata_p1 <= alu_data;
    end else if (pop && head_valid) begin
      we_p1    <= 1'b1;
      waddr_p1 <= head_rd;
      wdata_p1 <= head_data;
    end else begin
      we_p1    <= 1'b0;
    end
  end

  assign rf_we    = we_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

  assign lk_addr[0] = byp_addr1;
  assign lk_addr[1] = byp_addr2;

  // Queued data is younger than the value sitting in the write register.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      byp_hit[k]  = 1'b0;
      byp_data[k] = '0;
      if (lk_hit[k]) begin
        byp_hit[k]  = 1'b1;
        byp_data[k] = lk_data[k];
      end else if (we_p1 && (waddr_p1 == lk_addr[k]) && (lk_addr[k] != REG_ZERO)) begin
        byp_hit[k]  = 1'b1;
        byp_data[k] = wdata_p1;
      end
    end
  end

  assign byp_hit1  = byp_hit[0];
  assign byp_hit2  = byp_hit[1];
  assign byp_data1 = byp_data[0];
  assign byp_data2 = byp_data[1];

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  localparam int N      = 32;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_rd = '0;
  logic [N-1:0]  alu_data = '0;
  logic          alu_stall;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [4:0]    mem_rd = '0;
  logic [N-1:0]  mem_data = '0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [N-1:0]  rf_wdata;
  logic [4:0]    byp_addr1 = '0;
  logic [4:0]    byp_addr2 = '0;
  logic          byp_hit1;
  logic          byp_hit2;
  logic [N-1:0]  byp_data1;
  logic [N-1:0]  byp_data2;

  rf_writeback #(.N(N), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  // Reference model: pending memory results as a plain ordered list.
  typedef struct { bit v; bit [4:0] rd; bit [31:0] d; } ent_t;
  typedef struct { bit [4:0] rd; bit [31:0] d; } wr_t;
  ent_t        mq[$];
  wr_t         exp_q[$];
  int          age = 0;
  bit          m_we = 0;
  bit [4:0]    m_waddr = 0;
  bit [31:0]   m_wdata = 0;

  logic [31:0] shadow [32];
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  wr_t         mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_stall();
    return (mq.size() > 0) && mq[0].v && (age >= STARVE);
  endfunction

  task automatic model_byp(input bit [4:0] a, output bit hit, output bit [31:0] d);
    hit = 0;
    d   = 0;
    if (a != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].v && mq[i].rd == a) begin
          hit = 1;
          d   = mq[i].d;
        end
      end
      if (!hit && m_we && m_waddr == a) begin
        hit = 1;
        d   = m_wdata;
      end
    end
  endtask

  task automatic model_step(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                            input bit mv, input bit [4:0] mrd, input bit [31:0] md);
    int pre;
    bit ae;
    bit acc;
    bit popped;
    ent_t h;
    pre    = mq.size();
    ae     = av && ard != 0;
    acc    = mv && pre < DEPTH;
    popped = 0;
    if (ae) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].v = 0;
      exp_q.push_back('{rd: ard, d: ad});
      m_we = 1; m_waddr = ard; m_wdata = ad;
    end else if (pre > 0) begin
      h = mq.pop_front();
      popped = 1;
      if (h.v) begin
        exp_q.push_back('{rd: h.rd, d: h.d});
        m_we = 1; m_waddr = h.rd; m_wdata = h.d;
      end else begin
        m_we = 0;
      end
    end else begin
      m_we = 0;
    end
    if (acc && mrd != 0) mq.push_back('{v: !(ae && mrd == ard), rd: mrd, d: md});
    if (pre == 0 || popped) age = 0;
    else if (age < STARVE)  age = age + 1;
  endtask

  task automatic do_cycle(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                          input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                          input bit [4:0] b1, input bit [4:0] b2);
    bit h;
    bit [31:0] d;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    byp_addr1 = b1; byp_addr2 = b2;
    #1;
    if (av && model_stall()) begin
      viol++;
      $display("note: alu_valid driven while alu_stall is high (protocol violation %0d)", viol);
    end
    check("mem_ready", mem_ready, (mq.size() < DEPTH));
    check("alu_stall", alu_stall, model_stall());
    model_byp(b1, h, d);
    check("byp_hit1", byp_hit1, h);
    check("byp_data1", byp_data1, d);
    model_byp(b2, h, d);
    check("byp_hit2", byp_hit2, h);
    check("byp_data2", byp_data2, d);
    model_step(av, ard, ad, mv, mrd, md);
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    alu_valid = 0; mem_valid = 0;
    byp_addr1 = 5'd20; byp_addr2 = 5'd21;
    #1;
    check("rst_mid_we", rf_we, 0);
    check("rst_mid_ready", mem_ready, 1);
    check("rst_mid_stall", alu_stall, 0);
    check("rst_mid_hit1", byp_hit1, 0);
    check("rst_mid_hit2", byp_hit2, 0);
    mq.delete(); exp_q.delete();
    age = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: every cycle the write port either matches the next expected
  // write or holds its previous address/data with rf_we low.
  always @(negedge clk) begin
    if (rst) begin
      last_waddr = '0;
      last_wdata = '0;
    end else if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", rf_waddr, mon_e.rd);
        check("wr_data", rf_wdata, mon_e.d);
      end
      shadow[rf_waddr] = rf_wdata;
      last_waddr = rf_waddr;
      last_wdata = rf_wdata;
    end else begin
      check("missing_write", exp_q.size(), 0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      check("hold_addr", rf_waddr, last_waddr);
      check("hold_data", rf_wdata, last_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    byp_addr1 = 5'd5;
    repeat (2) @(negedge clk);
    #1;
    check("reset_we", rf_we, 0);
    check("reset_waddr", rf_waddr, 0);
    check("reset_wdata", rf_wdata, 0);
    check("reset_stall", alu_stall, 0);
    check("reset_ready", mem_ready, 1);
    check("reset_hit1", byp_hit1, 0);
    #1;
    rst = 1'b0;

    // ALU only
    do_cycle(1, 5, 32'hA5, 0, 0, 0, 0, 0);
    after_edge();
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 5);
    check("alu_wdata", rf_wdata, 32'hA5);
    do_cycle(1, 0, 32'h3C, 0, 0, 0, 0, 0);
    after_edge();
    check("alu_rd0_we", rf_we, 0);
    check("alu_rd0_hold", rf_waddr, 5);

    // Memory drain
    do_cycle(0, 0, 0, 1, 7, 32'h11, 0, 0);
    after_edge();
    check("mem_head_we", rf_we, 0);
    idle();
    after_edge();
    check("mem_we", rf_we, 1);
    check("mem_waddr", rf_waddr, 7);
    check("mem_wdata", rf_wdata, 32'h11);

    // Fill the FIFO while the ALU owns the port
    do_cycle(1, 1, 32'h101, 1, 10, 32'hAA, 0, 0);
    do_cycle(1, 2, 32'h102, 1, 11, 32'hBB, 10, 11);
    do_cycle(1, 1, 32'h103, 1, 12, 32'hCC, 0, 0);
    check("full_ready", mem_ready, 0);
    idle();
    check("full_ready_pop", mem_ready, 0);
    after_edge();
    check("ready_after_pop", mem_ready, 1);
    idle();
    idle();

    // Kill: queued rd=3 overtaken by ALU rd=3
    do_cycle(1, 4, 32'h44, 1, 3, 32'h1, 0, 0);
    do_cycle(1, 3, 32'h2, 0, 0, 0, 3, 0);
    idle();
    after_edge();
    check("killed_pop_we", rf_we, 0);
    check("rf3_after_kill", shadow[3], 32'h2);

    // Simultaneous ALU and memory write to rd=3
    do_cycle(1, 3, 32'h77, 1, 3, 32'h88, 0, 0);
    idle();
    idle();
    idle();
    check("rf3_simul", shadow[3], 32'h77);

    // Starvation
    do_cycle(1, 1, 32'h201, 1, 12, 32'h55, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle(1, 2, 32'h300 + i, 0, 0, 0, 12, 0);
    do_cycle(1, 2, 32'h303, 0, 0, 0, 12, 0);
    after_edge();
    check("starve_stall", alu_stall, 1);
    do_cycle(1, 2, 32'h304, 0, 0, 0, 0, 0);
    idle();
    after_edge();
    check("starve_release", alu_stall, 0);
    check("starve_waddr", rf_waddr, 12);
    check("starve_wdata", rf_wdata, 32'h55);

    // Bypass priority: FIFO over output register
    do_cycle(0, 0, 0, 1, 9, 32'h22, 0, 0);
    do_cycle(0, 0, 0, 1, 9, 32'h33, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 9, 0);
    check("byp_fifo_hit", byp_hit1, 1);
    check("byp_fifo_data", byp_data1, 32'h33);
    check("byp_zero_hit", byp_hit2, 0);
    check("byp_zero_data", byp_data2, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 9, 9);

    // Randomized traffic, protocol-respecting
    for (int i = 0; i < 400; i++) begin
      bit av;
      av = model_stall() ? 1'b0 : 1'($urandom % 2);
      do_cycle(av, 5'($urandom % 8), $urandom,
               1'($urandom % 2), 5'($urandom % 8), $urandom,
               5'($urandom % 8), 5'($urandom % 8));
    end
    repeat (4) idle();

    // Reset mid-operation with two entries queued
    do_cycle(1, 1, 32'h401, 1, 20, 32'hD0, 0, 0);
    do_cycle(1, 2, 32'h402, 1, 21, 32'hD1, 20, 21);
    pulse_reset();
    repeat (4) do_cycle(0, 0, 0, 0, 0, 0, 20, 21);
    after_edge();
    check("post_reset_we", rf_we, 0);
    repeat (2) idle();
    @(negedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
